// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchronised line, 3-sample majority per bit,
// optional parity, one-cycle data_valid with per-frame error flags.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);
    localparam int M       = OVERSAMPLE / 2;
    localparam int CW      = $clog2(OVERSAMPLE);
    localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int STOP_AT = (M + 2 < OVERSAMPLE) ? M + 2 : OVERSAMPLE - 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_STOP = CW'(STOP_AT);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q;
    logic                  rx_meta_q;
    logic                  rx_s_q;
    logic                  rx_d_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_q;
    logic [2:0]            smp_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  parity_error_q;
    logic                  stop_error_q;
    logic                  busy_q;

    logic [2:0] vote;
    logic       maj;
    logic       bit_end;
    logic       in_window;
    logic       fall;

    // The last vote sample is taken live when the decision lands on it.
    assign vote      = (cnt_q == CNT_HI) ? {smp_q[1:0], rx_s_q} : smp_q;
    assign maj       = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
    assign bit_end   = (cnt_q == CNT_LAST);
    assign in_window = (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
    assign fall      = rx_d_q & ~rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            rx_d_q         <= 1'b1;
            cnt_q          <= '0;
            bit_q          <= '0;
            smp_q          <= 3'b111;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            done_q         <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            rx_meta_q    <= rx_in;
            rx_s_q       <= rx_meta_q;
            rx_d_q       <= rx_s_q;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;

            if (done_q) begin
                data_out_q     <= shift_q;
                parity_error_q <= par_err_q;
                stop_error_q   <= stop_err_q;
                data_valid_q   <= 1'b1;
                busy_q         <= 1'b0;
            end

            if (state_q != S_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                if (in_window) begin
                    smp_q <= {smp_q[1:0], rx_s_q};
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_q   <= S_START;
                        cnt_q     <= CW'(1);
                        busy_q    <= 1'b1;
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_type;
                        par_err_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        if (maj) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        par_err_q <= maj ^ (^shift_q) ^ par_odd_q;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave early so the next start edge is never missed.
                    if (cnt_q == CNT_STOP) begin
                        stop_err_q <= ~maj;
                        done_q     <= 1'b1;
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomised serial frames for uart_rx_core, scored against a
// frame-level model of word, error flags and data_valid arrival cycle.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int DW = 8;
    localparam int OS = 8;
    localparam int M  = OS / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          parity_en;
    logic          parity_type;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          se;
        int            at;
    } exp_t;

    exp_t exp_q[$];
    int   dv_cyc_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_dv     = 0;
    int   n_exp    = 0;
    exp_t mon_e;

    uart_rx_core #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, int'(data_out), 0);
        check({tag, "_data_valid"}, int'(data_valid), 0);
        check({tag, "_parity_error"}, int'(parity_error), 0);
        check({tag, "_stop_error"}, int'(stop_error), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Caller is always #1 after a rising edge; the next edge is the first to see the start bit.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pty,
                              input logic bad_par, input logic stop_bit, input int rst_bit);
        logic bq[$];
        logic pbit;
        exp_t e;
        pbit = (^d) ^ pty ^ bad_par;
        bq.push_back(1'b0);
        for (int i = 0; i < DW; i++) bq.push_back(d[i]);
        if (pen) bq.push_back(pbit);
        bq.push_back(stop_bit);

        e.d  = d;
        e.pe = pen && (pbit != ((^d) ^ pty));
        e.se = !stop_bit;
        e.at = cyc + 1 + (bq.size() - 1) * OS + M + 5;
        if (rst_bit < 0) begin
            exp_q.push_back(e);
            n_exp++;
        end

        parity_en   = pen;
        parity_type = pty;
        for (int i = 0; i < bq.size(); i++) begin
            rx_in = bq[i];
            if (i == 1) begin
                parity_en   = 1'($urandom);
                parity_type = 1'($urandom);
            end
            tick(M);
            check("busy_mid_bit", int'(busy), 1);
            if (i == rst_bit) begin
                rst = 1'b1;
                #1;
                check_all_zero("rst_mid");
                tick(1);
                rst   = 1'b0;
                rx_in = 1'b1;
                return;
            end
            tick(OS - M);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            tick(1);
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        tick(4);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (data_valid === 1'b1) begin
                n_dv++;
                dv_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_dv", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dv_cycle", cyc, mon_e.at);
                    check("data_out", int'(data_out), int'(mon_e.d));
                    check("parity_error", int'(parity_error), int'(mon_e.pe));
                    check("stop_error", int'(stop_error), int'(mon_e.se));
                    check("busy_at_dv", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int saw_busy;
        logic [DW-1:0] d;
        logic pen, pty, bad, stp;
        int gap;

        rst = 1'b1; rx_in = 1'b1; parity_en = 1'b0; parity_type = 1'b0;
        tick(4);
        check_all_zero("reset");
        rst = 1'b0;
        tick(6);
        check("idle_busy", int'(busy), 0);

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        drain();
        check("a5_hold", int'(data_out), 8'hA5);
        check("a5_busy_after", int'(busy), 0);

        base = dv_cyc_q.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        rx_in = 1'b1;
        drain();
        if (dv_cyc_q.size() >= base + 2)
            check("b2b_spacing", dv_cyc_q[base+1] - dv_cyc_q[base], 80);
        else
            check("b2b_count", dv_cyc_q.size() - base, 2);

        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        drain();
        check("perr_hold", int'(parity_error), 1);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        drain();
        check("perr_cleared", int'(parity_error), 0);

        k = n_dv;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        tick(200);
        check("break_dv_count", n_dv - k, 1);
        check("break_stop_hold", int'(stop_error), 1);
        check("break_data_hold", int'(data_out), 8'h3C);
        rx_in = 1'b1;
        tick(20);
        send_frame(8'h99, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        drain();
        check("after_break_stop", int'(stop_error), 0);

        k = n_dv;
        saw_busy = 0;
        rx_in = 1'b0;
        tick(2);
        rx_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) saw_busy = 1;
        end
        check("glitch_busy_pulse", saw_busy, 1);
        check("glitch_busy_low", int'(busy), 0);
        check("glitch_no_dv", n_dv - k, 0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        drain();

        k = n_dv;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 5);
        tick(100);
        check("rst_no_dv", n_dv - k, 0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain();

        for (int n = 0; n < 40; n++) begin
            d   = DW'($urandom);
            pen = 1'($urandom_range(0, 1));
            pty = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 6) != 0);
            gap = $urandom_range(0, 12);
            if (!stp && gap == 0) gap = 1;
            send_frame(d, pen, pty, bad, stp, -1);
            rx_in = 1'b1;
            tick(gap);
        end
        drain();

        check("dv_total", n_dv, n_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Oversampling UART receiver that consumes the serial line driven by the team's UART transmitter (`tx_out`). It recovers 1 start bit, `DATA_WIDTH` data bits (LSB first), an optional parity bit, and 1 stop bit. Each frame is presented as a parallel word with a one-cycle `data_valid` pulse plus per-frame parity and framing error flags. It pairs with the transmitter to close the TX→RX loopback path.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `OVERSAMPLE`, default 8: clk cycles per bit. Must be even and ≥ 4.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_in`, in, 1: serial line. Idles high; asynchronous to `clk`.
- `parity_en`, in, 1: 1 means a parity bit follows the data bits.
- `parity_type`, in, 1: 0 selects even parity, 1 selects odd parity.
- `data_out`, out, `DATA_WIDTH`: last received word.
- `data_valid`, out, 1: one-cycle pulse when a frame completes.
- `parity_error`, out, 1: parity mismatch in the last frame.
- `stop_error`, out, 1: stop bit sampled low in the last frame.
- `busy`, out, 1: a frame is in progress.

## Operation
- **Input synchronizer.** `rx_in` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized `rx_s` and its previous value `rx_d`.
- **Control sampling.** `parity_en` and `parity_type` are sampled once, at start detection, and held for the whole frame.
- **Counters.**
  - Sample counter `cnt` runs 0..`OVERSAMPLE`-1 and wraps at each bit boundary.
  - Bit counter runs 0..`DATA_WIDTH`-1 in the DATA state.
- **Bit value.** Each bit's value is the majority of `rx_s` at `cnt` = M-1, M and M+1, where M = `OVERSAMPLE`/2.
- **States:**
  - **IDLE:** `busy`=0. A falling edge (`rx_d`=1, `rx_s`=0) moves to START. That cycle counts as `cnt`=0 of the start bit. A line held low never triggers a new frame; the line must return high first.
  - **START:** at `cnt`=`OVERSAMPLE`-1, a majority of 1 is a glitch: return to IDLE with no outputs changed. A majority of 0 moves to DATA.
  - **DATA:** at each bit end, shift the majority bit in LSB first. After bit `DATA_WIDTH`-1, go to PARITY if `parity_en`, else to STOP.
  - **PARITY:** at bit end, compute the expected parity bit:
    - even: XOR of the data bits;
    - odd: its inverse.
    - Record a mismatch internally, then go to STOP.
  - **STOP:** at `cnt`=M+2, once the majority is known, decide the frame and return to IDLE immediately. This allows back-to-back frames and half a bit of resynchronization margin.
- **Frame completion.** On the cycle after the STOP decision:
  - `data_out` is loaded with the shift register;
  - `parity_error` and `stop_error` are loaded with the frame's flags (`parity_error`=0 when parity is disabled);
  - `data_valid`=1 for exactly one cycle.
- **Errored frames.** Frames with errors are still delivered with `data_valid`. `data_out` and the error flags hold until the next `data_valid`.
- **Reset.** `rst` asserted at any time, including mid-frame:
  - state goes to IDLE and counters clear;
  - `data_out`=0, `data_valid`=0, `parity_error`=0, `stop_error`=0, `busy`=0;
  - no partial frame is ever delivered.

## Timing
- **Synchronizer latency:** 2 cycles from `rx_in` to `rx_s`.
- **`busy`:** rises on the cycle after start detection. Falls on the cycle after the STOP decision, the same cycle `data_valid` rises. A glitch drops `busy` on the cycle after START's bit end.
- **Frame latency.** Let B = 1 + `DATA_WIDTH` + `parity_en` + 1. Then `data_valid` rises (B-1)·`OVERSAMPLE` + M + 5 cycles after the first clk edge that samples `rx_in` low.
  - Defaults with parity: B=11, giving 89 cycles.
  - Defaults without parity: B=10, giving 81 cycles.
- **Back-to-back frames:** a new start edge is detected in the first IDLE cycle after STOP, so zero gap between frames is supported.
- **Glitch tolerance:** a low pulse shorter than M-1 cycles that starts in IDLE is rejected as a glitch.
- **Exact bit timing:** jitter of ±(M-2) cycles per bit edge is tolerated.

## Test plan
- **Odd parity, clean frame.** Drive 0xA5, `parity_en`=1, `parity_type`=1, parity bit 1, 8 cycles per bit → `data_out`=0xA5, `data_valid` for 1 cycle, both error flags 0, `busy` high for the frame.
- **Back-to-back, no parity.** Drive 0x55 then 0xAA with no idle gap, `parity_en`=0 → two `data_valid` pulses exactly 80 cycles apart; data 0x55 then 0xAA; no errors.
- **Parity error.** Drive 0x55 with `parity_en`=1, `parity_type`=0 (even) and parity bit 1 → `data_out`=0x55, `parity_error`=1, `stop_error`=0. A following correct frame clears `parity_error` to 0.
- **Stop error and break.** Drive 0x3C with the stop bit low, then hold the line low for 200 cycles → one frame with `data_out`=0x3C and `stop_error`=1; no further `data_valid` until the line goes high and then falls.
- **Start glitch.** Drive a 2-cycle low pulse from idle → `busy` pulses, no `data_valid`. A valid frame 0x81 right after is received correctly.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 of a frame → all outputs 0 immediately, no `data_valid` for that frame. The next full frame 0xF0 is received correctly.
